round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter_if.sv | 26 ++
 rtl/round_robin_arbiter.sv | 128 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle shared by the round-robin arbiter and its requesters.
// The arbiter attaches through the slave modport; requesters use master.
interface round_robin_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a rotating pointer, single registered owner and
// a hold limit that preempts a long-running owner when others are waiting.
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  round_robin_arbiter_if.slave bus
);
  localparam int         IDW       = $clog2(N);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]     state_reg,    state_next;
  logic [IDW-1:0] ptr_reg,      ptr_next;
  logic [7:0]     hold_cnt_reg, hold_cnt_next;
  logic [N-1:0]   grant_reg,    grant_next;
  logic [IDW-1:0] grant_id_reg, grant_id_next;

  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [N-1:0]   win_onehot;
  logic [IDW-1:0] off;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] win_ptr;
  logic           found;
  logic           owner_req;
  logic           take_new;

  // (a + b) mod N for operands already in 0..N-1
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input logic [IDW-1:0] b);
    logic [IDW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDW+1)'(N)) begin
      s = s - (IDW+1)'(N);
    end
    return s[IDW-1:0];
  endfunction

  // The owner is masked out, so after a release or preemption it ranks last;
  // in IDLE grant_reg is zero and every requester is a candidate.
  assign cand      = bus.request & ~grant_reg;
  assign owner_req = |(bus.request & grant_reg);
  assign found     = |cand;

  // rot[k] is the candidate k positions after the pointer
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot[gi] = cand[wrap_add(ptr_reg, IDW'(gi))];
  end

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IDW'(k);
      end
    end
  end

  assign win_id  = wrap_add(ptr_reg, off);
  assign win_ptr = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_id == IDW'(gi));
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    take_new      = 1'b0;

    if (state_reg == ST_IDLE) begin
      if (found) begin
        take_new = 1'b1;
      end
    end else begin
      if (!owner_req) begin
        // Release wins over a coincident timeout.
        if (found) begin
          take_new = 1'b1;
        end else begin
          state_next    = ST_IDLE;
          grant_next    = '0;
          hold_cnt_next = '0;
        end
      end else if (hold_cnt_reg == HOLD_LAST && found) begin
        take_new = 1'b1;
      end else if (hold_cnt_reg != HOLD_LAST) begin
        hold_cnt_next = hold_cnt_reg + 8'd1;
      end
    end

    if (take_new) begin
      state_next    = ST_BUSY;
      grant_next    = win_onehot;
      grant_id_next = win_id;
      ptr_next      = win_ptr;
      hold_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_valid = |grant_reg;
  assign bus.grant_id    = grant_id_reg;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (N=4, MAX_HOLD=8) with
// hand-computed grant sequences.
module tb_round_robin_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  round_robin_arbiter_if #(.N(N)) bus ();

  round_robin_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic v,
                            input logic [1:0] id);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
    check({tag, ".id"}, 32'(bus.grant_id), 32'(id));
    $display("[TB] %s req=%b grant=%b valid=%b id=%0d", tag, bus.request,
             bus.grant, bus.grant_valid, bus.grant_id);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    expect_out("reset_now", 4'b0000, 1'b0, 2'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] eid;
    rst_n       = 1'b0;
    bus.request = 4'b0000;
    #1;
    expect_out("por", 4'b0000, 1'b0, 2'd0);
    step();
    step();
    rst_n = 1'b1;

    // Idle with no requests
    for (int c = 0; c < 5; c++) begin
      step();
      expect_out("idle_quiet", 4'b0000, 1'b0, 2'd0);
    end

    // Single grant and release; id holds after release
    bus.request = 4'b0001;
    step();
    expect_out("single_grant", 4'b0001, 1'b1, 2'd0);
    bus.request = 4'b0000;
    step();
    expect_out("single_release", 4'b0000, 1'b0, 2'd0);

    // All requesting: each owner preempted after exactly 8 cycles
    do_reset();
    bus.request = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      eid = 2'((c / MAX_HOLD) % N);
      step();
      expect_out($sformatf("rotate_c%0d", c), 4'(1 << eid), 1'b1, eid);
    end

    // Owner 0 drops after 3 cycles; grant moves to 2 without a gap
    do_reset();
    bus.request = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_out("hold0", 4'b0001, 1'b1, 2'd0);
    end
    bus.request = 4'b0100;
    step();
    expect_out("handoff_to2", 4'b0100, 1'b1, 2'd2);

    // Grant to 3, release, then pointer wraps to 0
    bus.request = 4'b1000;
    step();
    expect_out("grant3", 4'b1000, 1'b1, 2'd3);
    bus.request = 4'b0000;
    step();
    expect_out("release3", 4'b0000, 1'b0, 2'd3);
    bus.request = 4'b0011;
    step();
    expect_out("wrap_to0", 4'b0001, 1'b1, 2'd0);

    // Sole requester keeps grant past the hold limit
    bus.request = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      step();
      expect_out("sole_hold", 4'b0001, 1'b1, 2'd0);
    end
    // Saturated owner preempted on the first edge another request appears
    bus.request = 4'b0011;
    step();
    expect_out("late_preempt", 4'b0010, 1'b1, 2'd1);

    // Asynchronous reset mid-grant clears outputs before the next edge
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 4'b0000, 1'b0, 2'd0);
    bus.request = 4'b1010;
    #1;
    rst_n = 1'b1;
    step();
    expect_out("post_reset", 4'b0010, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
